// File: rtl/fetch_prefetch_unit.sv
// fetch_prefetch_unit: fetches words into a prefetch FIFO for decode; a redirect flushes the FIFO and drops stale responses
module fetch_prefetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [31:0]       id_inst,
  output logic [ADDR_W-1:0] id_pc4,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [ADDR_W-1:0] fetch_pc;
  logic req_q, req_n, acc, rsp, push, pop;
  logic [CW-1:0] out_q, out_n, disc_q, disc_n, cnt_q, cnt_n;
  logic [PW-1:0] rd_q, wr_q, ard_q, awr_q;
  logic [31:0] inst_mem [DEPTH];
  logic [ADDR_W-1:0] pc4_mem [DEPTH];
  logic [ADDR_W-1:0] addr_mem [DEPTH];
  assign imem_req_valid = req_q && !(redirect_valid && !imem_req_ready);
  assign imem_req_addr = fetch_pc;
  assign acc = req_q && imem_req_ready;
  assign rsp = imem_rsp_valid && out_q != '0;
  assign push = rsp && disc_q == '0 && !redirect_valid;
  assign pop = id_valid && id_ready && !redirect_valid;
  assign id_valid = cnt_q != '0;
  assign id_inst = inst_mem[rd_q];
  assign id_pc4 = pc4_mem[rd_q];
  always_comb begin
    out_n = out_q + CW'(acc) - CW'(rsp);
    cnt_n = redirect_valid ? '0 : cnt_q + CW'(push) - CW'(pop);
    disc_n = redirect_valid ? out_n : disc_q - CW'(rsp && disc_q != '0);
    req_n = ({1'b0, cnt_n} + {1'b0, out_n}) < (CW + 1)'(DEPTH);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
      req_q <= 1'b0;
      out_q <= '0;
      disc_q <= '0;
      cnt_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      ard_q <= '0;
      awr_q <= '0;
      inst_mem <= '{default: '0};
      pc4_mem <= '{default: '0};
      addr_mem <= '{default: '0};
    end else begin
      fetch_pc <= redirect_valid ? (redirect_pc & ~ADDR_W'(3)) : acc ? fetch_pc + ADDR_W'(4) : fetch_pc;
      req_q <= req_n;
      out_q <= out_n;
      disc_q <= disc_n;
      cnt_q <= cnt_n;
      if (acc) addr_mem[awr_q] <= fetch_pc;
      awr_q <= awr_q + PW'(acc);
      ard_q <= ard_q + PW'(rsp);
      if (push) begin
        inst_mem[wr_q] <= imem_rsp_data;
        pc4_mem[wr_q] <= addr_mem[ard_q] + ADDR_W'(4);
      end
      wr_q <= redirect_valid ? '0 : wr_q + PW'(push);
      rd_q <= redirect_valid ? '0 : rd_q + PW'(pop);
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// tb_fetch_prefetch_unit: queue-level reference model of fetch_prefetch_unit driven by directed and random stimulus
module tb_fetch_prefetch_unit;
  localparam int DEPTH = 4;
  localparam logic [31:0] RESET_PC = 32'h0;
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] inst; logic [31:0] pc4; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mem_t;
  logic clk, reset;
  logic imem_req_valid, imem_req_ready, imem_rsp_valid, id_valid, id_ready, redirect_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, id_inst, id_pc4, redirect_pc;
  int total, bad, cyc;
  int lat_lo, lat_hi, rsp_pct, junk_pct;
  logic [31:0] xor_key;
  logic [31:0] m_pc;
  bit m_req;
  req_t m_out[$];
  ent_t m_fifo[$];
  mem_t mq[$];
  logic [31:0] acc_log[$];
  logic [31:0] seen[$];

  fetch_prefetch_unit #(.ADDR_W(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_inst(id_inst), .id_pc4(id_pc4),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    imem_req_ready = 1'b0;
    id_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_inst", id_inst, 32'd0);
    chk("rst_id_pc4", id_pc4, 32'd0);
    m_pc = RESET_PC;
    m_req = 1'b0;
    m_out.delete();
    m_fifo.delete();
    mq.delete();
    acc_log.delete();
    seen.delete();
    cyc = 0;
    reset = 1'b0;
  endtask

  task automatic step(input bit rdy, input bit idr, input bit redir, input logic [31:0] rpc);
    req_t r;
    ent_t e;
    mem_t m;
    bit acc, got;
    imem_req_ready = rdy;
    id_ready = idr;
    redirect_valid = redir;
    redirect_pc = rpc;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    if (mq.size() > 0) begin
      if (mq[0].due <= cyc && $urandom_range(99) < rsp_pct) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = mq[0].addr ^ xor_key;
      end
    end else if ($urandom_range(99) < junk_pct) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data = $urandom;
    end
    #1;
    chk("req_valid", 32'(imem_req_valid), 32'(m_req && !(redir && !rdy)));
    chk("req_addr", imem_req_addr, m_pc);
    chk("id_valid", 32'(id_valid), 32'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      chk("id_inst", id_inst, m_fifo[0].inst);
      chk("id_pc4", id_pc4, m_fifo[0].pc4);
    end
    if (id_valid && idr && !redir) seen.push_back(id_pc4);
    if (imem_rsp_valid && mq.size() > 0) m = mq.pop_front();
    if (imem_req_valid && rdy) begin
      mq.push_back('{imem_req_addr, cyc + int'($urandom_range(lat_hi, lat_lo))});
      acc_log.push_back(imem_req_addr);
    end
    acc = m_req && rdy;
    got = imem_rsp_valid && m_out.size() > 0;
    if (!redir && idr && m_fifo.size() > 0) e = m_fifo.pop_front();
    if (got) begin
      r = m_out.pop_front();
      if (!r.stale && !redir) m_fifo.push_back('{imem_rsp_data, r.addr + 32'd4});
    end
    if (acc) m_out.push_back('{m_pc, 1'b0});
    if (redir) begin
      m_fifo.delete();
      foreach (m_out[i]) m_out[i].stale = 1'b1;
      m_pc = rpc & ~32'h3;
    end else if (acc) m_pc = m_pc + 32'd4;
    m_req = (m_fifo.size() + m_out.size()) < DEPTH;
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    total = 0;
    bad = 0;
    lat_lo = 1;
    lat_hi = 1;
    rsp_pct = 100;
    junk_pct = 0;
    xor_key = '0;
    // streaming at full rate
    do_reset();
    repeat (20) step(1, 1, 0, 0);
    chk("t1_throughput", 32'(seen.size()), 32'd17);
    for (int k = 0; k < 6; k++) chk("t1_pc4_seq", seen[k], 32'(4 * (k + 1)));
    // decode stalled: FIFO fills, then drains and fetch resumes
    do_reset();
    repeat (12) step(1, 0, 0, 0);
    #1;
    chk("t2_req_count", 32'(acc_log.size()), 32'd4);
    chk("t2_req_off", 32'(imem_req_valid), 32'd0);
    chk("t2_head_inst", id_inst, 32'h0);
    chk("t2_head_pc4", id_pc4, 32'h4);
    repeat (12) step(1, 1, 0, 0);
    chk("t2_resume_addr", acc_log[4], 32'h10);
    for (int k = 0; k < 4; k++) chk("t2_drain_pc4", seen[k], 32'(4 * (k + 1)));
    // memory stall at 0x8
    do_reset();
    repeat (3) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    #1;
    chk("t3_hold_addr", imem_req_addr, 32'h8);
    chk("t3_hold_valid", 32'(imem_req_valid), 32'd1);
    repeat (10) step(1, 1, 0, 0);
    for (int k = 0; k < 5; k++) begin
      chk("t3_req_seq", acc_log[k], 32'(4 * k));
      chk("t3_pc4_seq", seen[k], 32'(4 * k + 4));
    end
    // redirect with two stale requests in flight
    do_reset();
    lat_lo = 3;
    lat_hi = 3;
    repeat (3) step(1, 1, 0, 0);
    step(0, 1, 1, 32'h103);
    repeat (10) step(1, 1, 0, 0);
    chk("t4_new_addr", acc_log[2], 32'h100);
    chk("t4_first_pc4", seen[0], 32'h104);
    // redirect coinciding with an acceptance and a response
    do_reset();
    lat_lo = 2;
    lat_hi = 2;
    repeat (3) step(1, 1, 0, 0);
    step(1, 1, 1, 32'h200);
    repeat (10) step(1, 1, 0, 0);
    chk("t5_old_acc", acc_log[2], 32'h8);
    chk("t5_new_addr", acc_log[3], 32'h200);
    chk("t5_first_pc4", seen[0], 32'h204);
    chk("t5_second_pc4", seen[1], 32'h208);
    // asynchronous reset with three entries buffered
    do_reset();
    lat_lo = 1;
    lat_hi = 1;
    repeat (5) step(1, 0, 0, 0);
    chk("t6_fill", 32'(m_fifo.size()), 32'd3);
    #2;
    chk("t6_pre_idv", 32'(id_valid), 32'd1);
    reset = 1'b1;
    #1;
    chk("t6_async_idv", 32'(id_valid), 32'd0);
    chk("t6_async_req", 32'(imem_req_valid), 32'd0);
    do_reset();
    repeat (4) step(1, 1, 0, 0);
    chk("t6_restart_addr", acc_log[0], RESET_PC);
    // randomized traffic
    do_reset();
    lat_lo = 1;
    lat_hi = 4;
    rsp_pct = 70;
    junk_pct = 10;
    xor_key = $urandom;
    for (int n = 0; n < 3000; n++)
      step($urandom_range(99) < 75, $urandom_range(99) < 70, $urandom_range(99) < 3,
           ($urandom_range(3) == 0) ? 32'hFFFF_FFF1 : $urandom);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
